// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Valid/ready request in, round-robin or fixed-priority grant, registered
// operands out to the ALU, registered result back on a per-port response.
module alu_share_arbiter #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       Req_valid,
  output logic [1:0]       Req_ready,
  input  logic [WIDTH-1:0] Req_a_0,
  input  logic [WIDTH-1:0] Req_a_1,
  input  logic [WIDTH-1:0] Req_b_0,
  input  logic [WIDTH-1:0] Req_b_1,
  input  logic [2:0]       Req_ctrl_0,
  input  logic [2:0]       Req_ctrl_1,
  output logic [1:0]       Rsp_valid,
  input  logic [1:0]       Rsp_ready,
  output logic [WIDTH-1:0] Rsp_result,
  output logic             Rsp_zero,
  output logic             Rsp_err,
  output logic [WIDTH-1:0] ALU_a,
  output logic [WIDTH-1:0] ALU_b,
  output logic [2:0]       ALU_control,
  input  logic [WIDTH-1:0] ALU_result,
  input  logic             ALU_zero,
  output logic             Busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q;
  logic   grant_id_q;
  logic   last_grant_q;
  logic   winner;
  logic   ctrl_legal;

  // Pick the winning port among the current requesters
  always_comb begin
    winner = 1'b0;
    case (Req_valid)
      2'b10:   winner = 1'b1;
      // Round-robin favours the port that did not win last time
      2'b11:   winner = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
      default: winner = 1'b0;
    endcase
  end

  // Decode whether the latched control code is one the ALU implements
  always_comb begin
    ctrl_legal = 1'b0;
    case (ALU_control)
      3'd0, 3'd1, 3'd2, 3'd6, 3'd7: ctrl_legal = 1'b1;
      default:                      ctrl_legal = 1'b0;
    endcase
  end

  // Ready only in IDLE and only to the winner; forced low while reset is held
  assign Req_ready = (rst_n && (state_q == StIdle) && (|Req_valid)) ?
                     (winner ? 2'b10 : 2'b01) : 2'b00;
  assign Rsp_valid = (state_q == StResp) ? (grant_id_q ? 2'b10 : 2'b01) : 2'b00;
  assign Busy      = (state_q != StIdle);

  // Arbitration FSM with registered operand and response state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      ALU_a        <= '0;
      ALU_b        <= '0;
      ALU_control  <= '0;
      Rsp_result   <= '0;
      Rsp_zero     <= 1'b0;
      Rsp_err      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|Req_valid) begin
            ALU_a       <= winner ? Req_a_1 : Req_a_0;
            ALU_b       <= winner ? Req_b_1 : Req_b_0;
            ALU_control <= winner ? Req_ctrl_1 : Req_ctrl_0;
            grant_id_q  <= winner;
            state_q     <= StExec;
          end
        end
        StExec: begin
          if (ctrl_legal) begin
            Rsp_result <= ALU_result;
            Rsp_zero   <= ALU_zero;
            Rsp_err    <= 1'b0;
          end else begin
            // ALU output is meaningless for unimplemented codes
            Rsp_result <= '0;
            Rsp_zero   <= 1'b1;
            Rsp_err    <= 1'b1;
          end
          state_q <= StResp;
        end
        StResp: begin
          if (Rsp_ready[grant_id_q]) begin
            last_grant_q <= grant_id_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]   req_valid, rsp_ready;
  logic [W-1:0] a0, b0, a1, b1;
  logic [2:0]   c0, c1;

  // Round-robin instance
  logic [1:0]   req_ready, rsp_valid;
  logic [W-1:0] rsp_result, alu_a, alu_b, alu_res;
  logic [2:0]   alu_ctrl;
  logic         rsp_zero, rsp_err, alu_zero, busy;

  // Fixed-priority instance, same inputs
  logic [1:0]   req_ready_fp, rsp_valid_fp;
  logic [W-1:0] rsp_result_fp, alu_a_fp, alu_b_fp, alu_res_fp;
  logic [2:0]   alu_ctrl_fp;
  logic         rsp_zero_fp, rsp_err_fp, alu_zero_fp, busy_fp;

  int checks   = 0;
  int failures = 0;

  // External ALU; unimplemented codes return junk the arbiter must ignore
  function automatic logic [W-1:0] alu_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] c);
    case (c)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd6:    return a - b;
      3'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_res     = alu_calc(alu_a, alu_b, alu_ctrl);
  assign alu_zero    = (alu_res == '0);
  assign alu_res_fp  = alu_calc(alu_a_fp, alu_b_fp, alu_ctrl_fp);
  assign alu_zero_fp = (alu_res_fp == '0);

  alu_share_arbiter #(.WIDTH(W), .FIXED_PRIORITY(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .Req_valid(req_valid), .Req_ready(req_ready),
    .Req_a_0(a0), .Req_a_1(a1), .Req_b_0(b0), .Req_b_1(b1),
    .Req_ctrl_0(c0), .Req_ctrl_1(c1), .Rsp_valid(rsp_valid), .Rsp_ready(rsp_ready),
    .Rsp_result(rsp_result), .Rsp_zero(rsp_zero), .Rsp_err(rsp_err),
    .ALU_a(alu_a), .ALU_b(alu_b), .ALU_control(alu_ctrl),
    .ALU_result(alu_res), .ALU_zero(alu_zero), .Busy(busy)
  );

  alu_share_arbiter #(.WIDTH(W), .FIXED_PRIORITY(1)) u_dut_fp (
    .clk(clk), .rst_n(rst_n), .Req_valid(req_valid), .Req_ready(req_ready_fp),
    .Req_a_0(a0), .Req_a_1(a1), .Req_b_0(b0), .Req_b_1(b1),
    .Req_ctrl_0(c0), .Req_ctrl_1(c1), .Rsp_valid(rsp_valid_fp), .Rsp_ready(rsp_ready),
    .Rsp_result(rsp_result_fp), .Rsp_zero(rsp_zero_fp), .Rsp_err(rsp_err_fp),
    .ALU_a(alu_a_fp), .ALU_b(alu_b_fp), .ALU_control(alu_ctrl_fp),
    .ALU_result(alu_res_fp), .ALU_zero(alu_zero_fp), .Busy(busy_fp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected response from the operation rules
  task automatic exp_rsp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                         output logic [W-1:0] res, output logic zero, output logic err);
    if (c == 3'd3 || c == 3'd4 || c == 3'd5) begin
      res = '0; zero = 1'b1; err = 1'b1;
    end else begin
      res = alu_calc(a, b, c); zero = (res == '0); err = 1'b0;
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    step();
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic [1:0]   valid;
    logic [2:0]   c0;
    logic [W-1:0] a0, b0;
    logic [2:0]   c1;
    logic [W-1:0] a1, b1;
    logic         port;
    logic [W-1:0] res;
    logic         zero;
    logic         err;
  } vec_t;

  vec_t tbl[12];

  // One full transaction from IDLE, checking every phase
  task automatic do_txn(input vec_t v, input int idx);
    logic [1:0] oh, fp_oh;
    oh    = v.port ? 2'b10 : 2'b01;
    fp_oh = (v.valid == 2'b11) ? 2'b01 : v.valid;
    req_valid = v.valid; rsp_ready = 2'b00;
    a0 = v.a0; b0 = v.b0; c0 = v.c0; a1 = v.a1; b1 = v.b1; c1 = v.c1;
    @(negedge clk);
    check($sformatf("v%0d req_ready", idx), req_ready, oh);
    check($sformatf("v%0d fp_req_ready", idx), req_ready_fp, fp_oh);
    check($sformatf("v%0d busy_idle", idx), busy, 1'b0);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check($sformatf("v%0d alu_a", idx), alu_a, v.port ? v.a1 : v.a0);
    check($sformatf("v%0d alu_b", idx), alu_b, v.port ? v.b1 : v.b0);
    check($sformatf("v%0d alu_ctrl", idx), alu_ctrl, v.port ? v.c1 : v.c0);
    check($sformatf("v%0d exec_rsp_valid", idx), rsp_valid, 2'b00);
    check($sformatf("v%0d exec_busy", idx), busy, 1'b1);
    step();
    @(negedge clk);
    check($sformatf("v%0d rsp_valid", idx), rsp_valid, oh);
    check($sformatf("v%0d rsp_result", idx), rsp_result, v.res);
    check($sformatf("v%0d rsp_zero", idx), rsp_zero, v.zero);
    check($sformatf("v%0d rsp_err", idx), rsp_err, v.err);
    check($sformatf("v%0d resp_req_ready", idx), req_ready, 2'b00);
    rsp_ready = 2'b11;
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    check($sformatf("v%0d done_busy", idx), busy, 1'b0);
    check($sformatf("v%0d done_rsp_valid", idx), rsp_valid, 2'b00);
    step();
  endtask

  // Transaction-level model state for the random run
  logic         m_pend, m_port, m_last, w, done;
  int           m_age;
  logic [W-1:0] m_a, m_b, m_res;
  logic [2:0]   m_c;
  logic         m_zero, m_err;

  function automatic logic [W-1:0] rnd_op();
    return ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; c0 = '0; c1 = '0;
    rsp_ready = 2'b00;

    // Reset state, with requests already pending
    rst_n = 1'b0; req_valid = 2'b11;
    @(negedge clk);
    check("rst req_ready", req_ready, 2'b00);
    check("rst rsp_valid", rsp_valid, 2'b00);
    check("rst alu_a", alu_a, '0);
    check("rst alu_ctrl", alu_ctrl, 3'd0);
    check("rst rsp_result", rsp_result, '0);
    check("rst rsp_zero", rsp_zero, 1'b0);
    check("rst rsp_err", rsp_err, 1'b0);
    check("rst busy", busy, 1'b0);
    req_valid = 2'b00;
    step();
    rst_n = 1'b1;
    step();

    // valid, c0, a0, b0, c1, a1, b1, port, result, zero, err
    tbl[0]  = '{2'b11, 3'd6, 32'd7, 32'd7, 3'd1, 32'd0, 32'd5, 1'b0, 32'd0, 1'b1, 1'b0};
    tbl[1]  = '{2'b11, 3'd6, 32'd7, 32'd7, 3'd1, 32'd0, 32'd5, 1'b1, 32'd5, 1'b0, 1'b0};
    tbl[2]  = '{2'b01, 3'd2, 32'd3, 32'd4, 3'd0, 32'd0, 32'd0, 1'b0, 32'd7, 1'b0, 1'b0};
    tbl[3]  = '{2'b10, 3'd0, 32'd0, 32'd0, 3'd4, 32'd9, 32'd9, 1'b1, 32'd0, 1'b1, 1'b1};
    tbl[4]  = '{2'b10, 3'd0, 32'd0, 32'd0, 3'd7, 32'd4, 32'd7, 1'b1, 32'd1, 1'b0, 1'b0};
    tbl[5]  = '{2'b01, 3'd7, 32'd9, 32'd2, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0};
    tbl[6]  = '{2'b11, 3'd0, 32'hF0, 32'h3C, 3'd1, 32'd1, 32'd2, 1'b1, 32'd3, 1'b0, 1'b0};
    tbl[7]  = '{2'b11, 3'd0, 32'hF0, 32'h3C, 3'd1, 32'd1, 32'd2, 1'b0, 32'h30, 1'b0, 1'b0};
    tbl[8]  = '{2'b01, 3'd6, 32'd5, 32'd5, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0};
    tbl[9]  = '{2'b10, 3'd0, 32'd0, 32'd0, 3'd3, 32'd1, 32'd1, 1'b1, 32'd0, 1'b1, 1'b1};
    tbl[10] = '{2'b10, 3'd0, 32'd0, 32'd0, 3'd5, 32'd2, 32'd3, 1'b1, 32'd0, 1'b1, 1'b1};
    tbl[11] = '{2'b01, 3'd6, 32'd0, 32'd1, 3'd0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) do_txn(tbl[i], i);

    // Back-pressure; port 0 keeps requesting while its response waits
    req_valid = 2'b01; a0 = 32'd10; b0 = 32'd20; c0 = 3'd2; rsp_ready = 2'b00;
    step();
    step();
    for (int i = 0; i < 7; i++) begin
      if (i == 5) rsp_ready = 2'b10;
      @(negedge clk);
      check("bp rsp_valid", rsp_valid, 2'b01);
      check("bp rsp_result", rsp_result, 32'd30);
      check("bp req_ready", req_ready, 2'b00);
      check("bp busy", busy, 1'b1);
      step();
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    check("bp release rsp_valid", rsp_valid, 2'b01);
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    check("bp after req_ready", req_ready, 2'b01);
    check("bp after busy", busy, 1'b0);
    check("bp after rsp_valid", rsp_valid, 2'b00);
    step();
    req_valid = 2'b00;
    step();
    @(negedge clk);
    check("bp second rsp_valid", rsp_valid, 2'b01);
    check("bp second rsp_result", rsp_result, 32'd30);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;

    // Reset during EXEC: port 0 had the last grant, reset must restore port 1
    req_valid = 2'b01; a0 = 32'd123; b0 = 32'd1; c0 = 3'd2;
    step();
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    check("midrst alu_a", alu_a, '0);
    check("midrst alu_ctrl", alu_ctrl, 3'd0);
    check("midrst busy", busy, 1'b0);
    check("midrst req_ready", req_ready, 2'b00);
    check("midrst rsp_valid", rsp_valid, 2'b00);
    step();
    rst_n = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst no_rsp", rsp_valid, 2'b00);
      step();
    end
    req_valid = 2'b11;
    @(negedge clk);
    check("midrst contention", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    repeat (3) step();
    rsp_ready = 2'b00;

    // Randomized run against the transaction model
    do_reset();
    m_pend = 1'b0; m_last = 1'b1; m_age = 0; m_port = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      req_valid = 2'($urandom); rsp_ready = 2'($urandom);
      a0 = rnd_op(); b0 = rnd_op(); a1 = rnd_op(); b1 = rnd_op();
      c0 = 3'($urandom); c1 = 3'($urandom);
      @(negedge clk);
      done = 1'b0;
      if (!m_pend) begin
        check("rnd idle rsp_valid", rsp_valid, 2'b00);
        check("rnd idle busy", busy, 1'b0);
        if (req_valid != 2'b00) begin
          w = (req_valid == 2'b01) ? 1'b0 : (req_valid == 2'b10) ? 1'b1 : ~m_last;
          check("rnd req_ready", req_ready, w ? 2'b10 : 2'b01);
          m_pend = 1'b1; m_port = w; m_age = 0;
          m_a = w ? a1 : a0; m_b = w ? b1 : b0; m_c = w ? c1 : c0;
          exp_rsp(m_a, m_b, m_c, m_res, m_zero, m_err);
        end else begin
          check("rnd idle req_ready", req_ready, 2'b00);
        end
      end else begin
        check("rnd busy req_ready", req_ready, 2'b00);
        check("rnd busy", busy, 1'b1);
        if (m_age == 1) begin
          check("rnd exec rsp_valid", rsp_valid, 2'b00);
          check("rnd alu_a", alu_a, m_a);
          check("rnd alu_b", alu_b, m_b);
          check("rnd alu_ctrl", alu_ctrl, m_c);
        end else begin
          check("rnd rsp_valid", rsp_valid, m_port ? 2'b10 : 2'b01);
          check("rnd rsp_result", rsp_result, m_res);
          check("rnd rsp_zero", rsp_zero, m_zero);
          check("rnd rsp_err", rsp_err, m_err);
          if (rsp_ready[m_port]) done = 1'b1;
        end
      end
      step();
      if (m_pend) m_age++;
      if (done) begin
        m_pend = 1'b0;
        m_last = m_port;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
